cellrv32_cpu_cp_arbiter: RTL

//  Dispatch stage directly upstream of every CPU co-processor (Zicond, shifter, muldiv, ...).

---
 rtl/cellrv32_cpu_cp_arbiter_pkg.sv | 23 ++
 rtl/cellrv32_cpu_cp_arbiter_if.sv | 28 ++
 rtl/cellrv32_cpu_cp_arbiter_tmo.sv | 37 +++
 rtl/cellrv32_cpu_cp_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cellrv32_cpu_cp_arbiter_pkg.sv
// Shared types and constants for the co-processor dispatch arbiter.
// Holds the arbiter FSM state encoding, the CP slot count and slot indices.
package cellrv32_package;

    typedef enum logic [1:0] {
        CP_IDLE,
        CP_DISPATCH,
        CP_WAIT,
        CP_CAPTURE
    } cp_arb_state_t;

    localparam int CP_ARB_NUM_C = 8;

    localparam int CP_SEL_COND_C     = 0;
    localparam int CP_SEL_SHIFT_C    = 1;
    localparam int CP_SEL_MULDIV_C   = 2;
    localparam int CP_SEL_BITMANIP_C = 3;
    localparam int CP_SEL_FPU_C      = 4;
    localparam int CP_SEL_CFU_C      = 5;
    localparam int CP_SEL_CRYPTO_C   = 6;
    localparam int CP_SEL_RSVD_C     = 7;

endpackage

// File: rtl/cellrv32_cpu_cp_arbiter_if.sv
// Dispatch bus between CPU control, the co-processors and the arbiter.
// master: control/CP side (drives start/sel/kill/cp_valid/cp_res);
// slave: arbiter (drives cp_start/res/valid/busy/err).
interface cellrv32_cpu_cp_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int NUM_CP = 8
);
    logic                     start_i;
    logic [NUM_CP-1:0]        sel_i;
    logic                     kill_i;
    logic [NUM_CP-1:0]        cp_start_o;
    logic [NUM_CP-1:0]        cp_valid_i;
    logic [NUM_CP*XLEN-1:0]   cp_res_i;
    logic [XLEN-1:0]          res_o;
    logic                     valid_o;
    logic                     busy_o;
    logic                     err_o;

    modport master (
        output start_i, sel_i, kill_i, cp_valid_i, cp_res_i,
        input  cp_start_o, res_o, valid_o, busy_o, err_o
    );

    modport slave (
        input  start_i, sel_i, kill_i, cp_valid_i, cp_res_i,
        output cp_start_o, res_o, valid_o, busy_o, err_o
    );
endinterface

// File: rtl/cellrv32_cpu_cp_arbiter_tmo.sv
// WAIT-state watchdog: clr_i zeroes, en_i counts, expire_o on last count.
// Ports: clk_i, rst_i, clr_i, en_i, expire_o. Built with CELLRV32_CP_TIMEOUT_EN.
`ifdef CELLRV32_CP_TIMEOUT_EN
module cellrv32_cpu_cp_tmo #(
    parameter int TMO_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == W'(TMO_CYC - 1));
endmodule
`endif

// File: rtl/cellrv32_cpu_cp_arbiter.sv
// Co-processor dispatch arbiter: one start pulse to the selected CP, waits
// for its valid, captures the OR of all CP results as a registered result.
// Ports: clk_i, rst_i (async, active-high), bus (slave modport).
// Optional WAIT timeout: define CELLRV32_CP_TIMEOUT_EN (TMO_CYC parameter).
module cellrv32_cpu_cp_arbiter
    import cellrv32_package::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_CP = CP_ARB_NUM_C
`ifdef CELLRV32_CP_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 64
`endif
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cellrv32_cpu_cp_arbiter_if.slave    bus
);
    function automatic logic is_onehot(input logic [NUM_CP-1:0] v);
        return (v != '0) && ((v & (v - NUM_CP'(1))) == '0);
    endfunction

    // Idle CPs drive zero, so OR-ing all slots yields the active result.
    function automatic logic [XLEN-1:0] or_reduce(
        input logic [NUM_CP*XLEN-1:0] r
    );
        logic [XLEN-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            acc = acc | r[i*XLEN +: XLEN];
        end
        return acc;
    endfunction

    cp_arb_state_t     state_q, state_d;
    logic [NUM_CP-1:0] sel_q, sel_d;
    logic [NUM_CP-1:0] cp_start_q, cp_start_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              sel_hit;
    logic              tmo_exp;

    assign sel_hit = |(bus.cp_valid_i & sel_q);

`ifdef CELLRV32_CP_TIMEOUT_EN
    cellrv32_cpu_cp_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q == CP_DISPATCH),
        .en_i     (state_q == CP_WAIT),
        .expire_o (tmo_exp)
    );
`else
    assign tmo_exp = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= CP_IDLE;
            sel_q      <= '0;
            cp_start_q <= '0;
            res_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cp_start_q <= cp_start_d;
            res_q      <= res_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // kill_i wins over start, valid and timeout in every state.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            CP_IDLE: begin
                if (!bus.kill_i && bus.start_i && is_onehot(bus.sel_i)) begin
                    state_d = CP_DISPATCH;
                    sel_d   = bus.sel_i;
                end
            end
            CP_DISPATCH: begin
                if (bus.kill_i)   state_d = CP_IDLE;
                else if (sel_hit) state_d = CP_CAPTURE;
                else              state_d = CP_WAIT;
            end
            CP_WAIT: begin
                if (bus.kill_i)   state_d = CP_IDLE;
                else if (sel_hit) state_d = CP_CAPTURE;
                else if (tmo_exp) state_d = CP_IDLE;
            end
            CP_CAPTURE: state_d = CP_IDLE;
            default:    state_d = CP_IDLE;
        endcase
    end

    always_comb begin
        cp_start_d = '0;
        res_d      = res_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            CP_IDLE: begin
                if (!bus.kill_i && bus.start_i) begin
                    if (is_onehot(bus.sel_i)) cp_start_d = bus.sel_i;
                    else                      err_d      = 1'b1;
                end
            end
            CP_WAIT: begin
                if (!bus.kill_i && !sel_hit && tmo_exp) begin
                    err_d = 1'b1;
                    res_d = '0;
                end
            end
            CP_CAPTURE: begin
                if (!bus.kill_i) begin
                    res_d   = or_reduce(bus.cp_res_i);
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.cp_start_o = cp_start_q;
    assign bus.res_o      = res_q;
    assign bus.valid_o    = valid_q;
    assign bus.err_o      = err_q;
    assign bus.busy_o     = (state_q != CP_IDLE);
endmodule
